// File: rtl/ioctl_sdram_packer.sv
// ioctl_sdram_packer
//   Packs the ARM->FPGA download byte stream into 16-bit SDRAM words. The
//   packer merges adjacent bytes that fall in the same word. Finished words
//   wait in a 4-entry FIFO and are written out through a req/ack handshake.
//   clkref_n paces the download stage so that a byte is only offered when the
//   FIFO can still take a word.
//
// Ports
//   clk_sys         system clock, all logic on posedge
//   rst             asynchronous active-high reset
//   ioctl_download  download active
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr      byte address (25 bits)
//   ioctl_dout      byte data
//   clkref_n        low = a byte may be offered next cycle (registered)
//   sdram_req       write request, held until sdram_ack
//   sdram_addr      word address
//   sdram_data      write data
//   sdram_mask      active-high byte disable, [1]=data[15:8], [0]=data[7:0]
//   sdram_ack       one-cycle acceptance of the current request
//   busy            pending word valid, FIFO non-empty or request outstanding
//   dwnld_done      one-cycle pulse once a finished download has fully drained
//   overflow        sticky, a byte was dropped because the FIFO was full
module ioctl_sdram_packer #(
    parameter int unsigned SDRAM_AW  = 22,
    parameter bit          SWAB      = 1'b0,
    parameter int unsigned BA_OFFSET = 0
) (
    input  logic                clk_sys,
    input  logic                rst,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    output logic                clkref_n,
    output logic                sdram_req,
    output logic [SDRAM_AW-1:0] sdram_addr,
    output logic [15:0]         sdram_data,
    output logic [1:0]          sdram_mask,
    input  logic                sdram_ack,
    output logic                busy,
    output logic                dwnld_done,
    output logic                overflow
);

    localparam logic [SDRAM_AW-1:0] LP_BA = SDRAM_AW'(BA_OFFSET);

    typedef struct packed {
        logic [SDRAM_AW-1:0] addr;
        logic [15:0]         data;
        logic [1:0]          mask;
    } word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP
    } state_t;

    // Download edge detection
    logic                r_dl_q;
    logic                w_dl_rise;
    logic                w_dl_fall;

    // Incoming byte decode
    logic                w_in_range;
    logic                w_accept;
    logic                w_lane;
    logic [1:0]          w_lane_bit;
    logic [SDRAM_AW-1:0] w_waddr;

    // Pending word
    word_t               r_pend;
    logic                r_pend_v;
    logic                w_pend_v;
    logic                w_merge;
    logic                w_load_new;

    // FIFO
    word_t               r_fifo [4];
    logic [1:0]          r_wr_ptr;
    logic [1:0]          r_rd_ptr;
    logic [2:0]          r_count;
    logic                w_fifo_full;
    logic                w_push_new;
    logic                w_push_done;
    logic                w_push_flush;
    logic                w_push_req;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;

    // Handshake and status registers
    state_t              r_state;
    logic                r_sdram_req;
    logic [SDRAM_AW-1:0] r_sdram_addr;
    logic [15:0]         r_sdram_data;
    logic [1:0]          r_sdram_mask;
    logic                r_clkref_n;
    logic                r_done;
    logic                r_done_arm;
    logic                r_overflow;

    assign w_dl_rise  = ioctl_download & ~r_dl_q;
    assign w_dl_fall  = ~ioctl_download & r_dl_q;

    assign w_in_range = ((ioctl_addr >> (SDRAM_AW + 1)) == '0);
    assign w_accept   = ioctl_wr & ioctl_download & w_in_range;
    assign w_lane     = ioctl_addr[0] ^ SWAB;
    assign w_lane_bit = w_lane ? 2'b01 : 2'b10;
    assign w_waddr    = ioctl_addr[SDRAM_AW:1] + LP_BA;

    // A download start discards whatever was pending, so a byte arriving on
    // the rising-edge cycle is treated as if nothing were pending.
    assign w_pend_v   = r_pend_v & ~w_dl_rise;

    assign w_merge    = w_accept & w_pend_v & (w_waddr == r_pend.addr)
                      & (|(r_pend.mask & w_lane_bit));

    assign w_fifo_full  = (r_count == 3'd4);

    // Three reasons to move the pending word into the FIFO:
    //  - a new byte that cannot be merged displaces it
    //  - it became complete (both lanes written) on an earlier cycle
    //  - the download has ended; retried every cycle until the FIFO has room,
    //    which also covers a flush that coincides with a full FIFO
    assign w_push_new   = w_accept & w_pend_v & ~w_merge;
    assign w_push_done  = ~w_accept & w_pend_v & (r_pend.mask == 2'b00);
    assign w_push_flush = ~ioctl_download & r_pend_v;
    assign w_push_req   = w_push_new | w_push_done | w_push_flush;
    assign w_push       = w_push_req & ~w_fifo_full;
    assign w_drop       = w_push_new & w_fifo_full;
    assign w_load_new   = w_accept & (~w_pend_v | (w_push_new & ~w_fifo_full));

    assign w_pop        = (r_state == ST_REQ) & sdram_ack;

    // Pending word and edge detect
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_dl_q   <= 1'b0;
            r_pend_v <= 1'b0;
            r_pend   <= '0;
        end else begin
            r_dl_q <= ioctl_download;
            if (w_merge) begin
                r_pend.mask <= r_pend.mask & ~w_lane_bit;
                if (w_lane) begin
                    r_pend.data[7:0] <= ioctl_dout;
                end else begin
                    r_pend.data[15:8] <= ioctl_dout;
                end
            end else if (w_load_new) begin
                r_pend.addr <= w_waddr;
                r_pend.data <= w_lane ? {8'h00, ioctl_dout} : {ioctl_dout, 8'h00};
                r_pend.mask <= ~w_lane_bit;
                r_pend_v    <= 1'b1;
            end else if (w_push || w_dl_rise) begin
                r_pend_v <= 1'b0;
            end
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by r_count
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= r_pend;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_clkref_n <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};

            if (w_dl_rise) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end

            // Offer a byte only while at least two entries are free
            r_clkref_n <= ~(ioctl_download & (r_count <= 3'd2));
        end
    end

    // SDRAM write handshake
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rd_ptr     <= '0;
            r_sdram_req  <= 1'b0;
            r_sdram_addr <= '0;
            r_sdram_data <= '0;
            r_sdram_mask <= 2'b11;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_count != 3'd0) begin
                        r_sdram_addr <= r_fifo[r_rd_ptr].addr;
                        r_sdram_data <= r_fifo[r_rd_ptr].data;
                        r_sdram_mask <= r_fifo[r_rd_ptr].mask;
                        r_sdram_req  <= 1'b1;
                        r_state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) begin
                        r_sdram_req <= 1'b0;
                        r_rd_ptr    <= r_rd_ptr + 2'd1;
                        r_state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Completion: armed by the falling edge, fires once everything drained.
    // A new download start cancels an armed but not yet fired completion.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_done     <= 1'b0;
            r_done_arm <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_dl_rise) begin
                r_done_arm <= 1'b0;
            end else if (w_dl_fall) begin
                r_done_arm <= 1'b1;
            end else if (r_done_arm && !r_pend_v && (r_count == 3'd0)
                         && (r_state == ST_IDLE)) begin
                r_done     <= 1'b1;
                r_done_arm <= 1'b0;
            end
        end
    end

    assign clkref_n   = r_clkref_n;
    assign sdram_req  = r_sdram_req;
    assign sdram_addr = r_sdram_addr;
    assign sdram_data = r_sdram_data;
    assign sdram_mask = r_sdram_mask;
    assign dwnld_done = r_done;
    assign overflow   = r_overflow;
    assign busy       = r_pend_v | (r_count != 3'd0) | r_sdram_req;

endmodule

// File: tb/tb_ioctl_sdram_packer.sv
module tb_ioctl_sdram_packer;

    logic        clk_sys;
    logic        rst;

    // DUT 1: default parameters
    logic        dl1, wr1, ack1;
    logic [24:0] addr1;
    logic [7:0]  dout1;
    logic        clkref_n1, req1, busy1, done1, ovf1;
    logic [21:0] saddr1;
    logic [15:0] sdata1;
    logic [1:0]  smask1;

    // DUT 2: swapped lanes with a base offset
    logic        dl2, wr2, ack2;
    logic [24:0] addr2;
    logic [7:0]  dout2;
    logic        clkref_n2, req2, busy2, done2, ovf2;
    logic [21:0] saddr2;
    logic [15:0] sdata2;
    logic [1:0]  smask2;

    ioctl_sdram_packer #(.SDRAM_AW(22), .SWAB(1'b0), .BA_OFFSET(0)) dut1 (
        .clk_sys(clk_sys), .rst(rst), .ioctl_download(dl1), .ioctl_wr(wr1),
        .ioctl_addr(addr1), .ioctl_dout(dout1), .clkref_n(clkref_n1),
        .sdram_req(req1), .sdram_addr(saddr1), .sdram_data(sdata1),
        .sdram_mask(smask1), .sdram_ack(ack1), .busy(busy1),
        .dwnld_done(done1), .overflow(ovf1)
    );

    ioctl_sdram_packer #(.SDRAM_AW(22), .SWAB(1'b1), .BA_OFFSET(32'h100)) dut2 (
        .clk_sys(clk_sys), .rst(rst), .ioctl_download(dl2), .ioctl_wr(wr2),
        .ioctl_addr(addr2), .ioctl_dout(dout2), .clkref_n(clkref_n2),
        .sdram_req(req2), .sdram_addr(saddr2), .sdram_data(sdata2),
        .sdram_mask(smask2), .sdram_ack(ack2), .busy(busy2),
        .dwnld_done(done2), .overflow(ovf2)
    );

    typedef struct {
        logic [21:0] addr;
        logic [15:0] data;
        logic [1:0]  mask;
        int unsigned cyc;
    } wr_t;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  dout;
        int unsigned n_exp;
        logic [21:0] e_addr;
        logic [15:0] e_data;
        logic [1:0]  e_mask;
    } vec_t;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    int unsigned done_cnt1 = 0;
    int unsigned done_cnt2 = 0;

    wr_t cap1[$];
    wr_t cap2[$];

    bit          ack_hold = 1'b0;
    bit          spurious = 1'b0;
    int unsigned ack_max  = 0;
    int unsigned ack_wait = 0;
    int unsigned ack_dly  = 0;

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    always @(posedge clk_sys) cyc <= cyc + 1;

    // SDRAM side responder and event monitor, all on the falling edge
    initial begin
        wr_t w;
        ack1 = 1'b0;
        ack2 = 1'b0;
        forever begin
            @(negedge clk_sys);
            ack1 = 1'b0;
            ack2 = 1'b0;
            if (done1 === 1'b1) done_cnt1++;
            if (done2 === 1'b1) done_cnt2++;
            if (req1 === 1'b1 && !rst) begin
                if (!ack_hold) begin
                    if (ack_wait >= ack_dly) begin
                        ack1 = 1'b1;
                        w.addr = saddr1; w.data = sdata1; w.mask = smask1; w.cyc = cyc;
                        cap1.push_back(w);
                        ack_wait = 0;
                        ack_dly = $urandom_range(ack_max, 0);
                    end else begin
                        ack_wait++;
                    end
                end
            end else begin
                ack_wait = 0;
                if (spurious && $urandom_range(7, 0) == 0) ack1 = 1'b1;
            end
            if (req2 === 1'b1 && !rst) begin
                ack2 = 1'b1;
                w.addr = saddr2; w.data = sdata2; w.mask = smask2; w.cyc = cyc;
                cap2.push_back(w);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time=%0t want finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    // Data bytes in masked lanes are don't-care
    task automatic check_word(input string name, input wr_t act, input wr_t exp);
        logic [15:0] en;
        en = {{8{~exp.mask[1]}}, {8{~exp.mask[0]}}};
        total++;
        if (act.addr !== exp.addr || act.mask !== exp.mask || (act.data & en) !== (exp.data & en)) begin
            bad++;
            $display("FAIL %s: got addr=%h data=%h mask=%b want addr=%h data=%h mask=%b",
                     name, act.addr, act.data, act.mask, exp.addr, exp.data, exp.mask);
        end
    endtask

    function automatic wr_t mk(input logic [21:0] a, input logic [15:0] d, input logic [1:0] m);
        wr_t w;
        w.addr = a; w.data = d; w.mask = m; w.cyc = 0;
        return w;
    endfunction

    task automatic cap_word(input string name, input int unsigned idx, input wr_t exp);
        if (idx < cap1.size()) check_word(name, cap1[idx], exp);
        else begin
            total++; bad++;
            $display("FAIL %s: got no write want addr=%h", name, exp.addr);
        end
    endtask

    // All driving tasks start and end just after a falling edge
    task automatic start_dl();
        int unsigned g = 0;
        dl1 = 1'b1;
        @(negedge clk_sys);
        while (clkref_n1 !== 1'b0 && g < 20) begin
            @(negedge clk_sys);
            g++;
        end
        if (clkref_n1 !== 1'b0) fail_now("start_clkref");
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit pace, input bit gaps);
        int unsigned g = 0;
        while (pace && (clkref_n1 !== 1'b0 || (gaps && $urandom_range(3, 0) == 0)) && g < 500) begin
            @(negedge clk_sys);
            g++;
        end
        if (g >= 500) fail_now("pace_wait");
        wr1 = 1'b1; addr1 = a; dout1 = d;
        @(negedge clk_sys);
        wr1 = 1'b0;
    endtask

    task automatic wait_done(input int unsigned snap, input string name);
        int unsigned g = 0;
        while (done_cnt1 == snap && g < 400) begin
            @(negedge clk_sys);
            g++;
        end
        if (done_cnt1 == snap) fail_now(name);
        repeat (6) @(negedge clk_sys);
    endtask

    initial begin
        vec_t        vecs[7];
        int unsigned snap;
        int unsigned fall_cyc;
        wr_t         exp_q[$];
        logic [24:0] ba[$];
        logic [7:0]  bd[$];
        logic [24:0] a, prev;
        logic [7:0]  d;
        logic [21:0] wa;
        logic [1:0]  bitm;
        bit          cv;
        wr_t         cw;
        int unsigned n, r;

        vecs[0] = '{25'h0000000, 8'h11, 1, 22'h000000, 16'h1100, 2'b01};
        vecs[1] = '{25'h0000001, 8'h22, 1, 22'h000000, 16'h0022, 2'b10};
        vecs[2] = '{25'h0000101, 8'h33, 1, 22'h000080, 16'h0033, 2'b10};
        vecs[3] = '{25'h07FFFFF, 8'h44, 1, 22'h3FFFFF, 16'h0044, 2'b10};
        vecs[4] = '{25'h07FFFFE, 8'h55, 1, 22'h3FFFFF, 16'h5500, 2'b01};
        vecs[5] = '{25'h0800000, 8'h66, 0, 22'h000000, 16'h0000, 2'b11};
        vecs[6] = '{25'h1FFFFFF, 8'h77, 0, 22'h000000, 16'h0000, 2'b11};

        rst = 1'b1;
        dl1 = 1'b0; wr1 = 1'b0; addr1 = '0; dout1 = '0;
        dl2 = 1'b0; wr2 = 1'b0; addr2 = '0; dout2 = '0;
        repeat (3) @(negedge clk_sys);

        // Reset state
        check("rst_clkref", clkref_n1, 1);
        check("rst_req", req1, 0);
        check("rst_addr_data", {saddr1, sdata1}, 0);
        check("rst_mask", smask1, 2'b11);
        check("rst_flags", {busy1, done1, ovf1}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk_sys);

        // Single-byte downloads: lane selection, address range boundaries
        for (int i = 0; i < 7; i++) begin
            cap1.delete();
            snap = done_cnt1;
            start_dl();
            send_byte(vecs[i].addr, vecs[i].dout, 1'b1, 1'b0);
            dl1 = 1'b0;
            wait_done(snap, $sformatf("vec%0d_done", i));
            check($sformatf("vec%0d_count", i), cap1.size(), vecs[i].n_exp);
            if (vecs[i].n_exp == 1)
                cap_word($sformatf("vec%0d_word", i), 0, mk(vecs[i].e_addr, vecs[i].e_data, vecs[i].e_mask));
        end

        // Contiguous four bytes, immediate acks
        cap1.delete();
        snap = done_cnt1;
        start_dl();
        send_byte(25'd0, 8'h11, 1'b1, 1'b0);
        send_byte(25'd1, 8'h22, 1'b1, 1'b0);
        send_byte(25'd2, 8'h33, 1'b1, 1'b0);
        send_byte(25'd3, 8'h44, 1'b1, 1'b0);
        dl1 = 1'b0;
        wait_done(snap, "contig_done");
        repeat (10) @(negedge clk_sys);
        check("contig_count", cap1.size(), 2);
        cap_word("contig_w0", 0, mk(22'd0, 16'h1122, 2'b00));
        cap_word("contig_w1", 1, mk(22'd1, 16'h3344, 2'b00));
        check("contig_done_once", done_cnt1 - snap, 1);

        // Odd length: last half word only leaves on the falling edge
        cap1.delete();
        snap = done_cnt1;
        start_dl();
        send_byte(25'd0, 8'hAA, 1'b1, 1'b0);
        send_byte(25'd1, 8'hBB, 1'b1, 1'b0);
        send_byte(25'd2, 8'hCC, 1'b1, 1'b0);
        repeat (8) @(negedge clk_sys);
        dl1 = 1'b0;
        fall_cyc = cyc;
        wait_done(snap, "odd_done");
        check("odd_count", cap1.size(), 2);
        cap_word("odd_w0", 0, mk(22'd0, 16'hAABB, 2'b00));
        cap_word("odd_w1", 1, mk(22'd1, 16'hCC00, 2'b01));
        if (cap1.size() == 2) check("odd_after_fall", cap1[1].cyc > fall_cyc, 1);

        // Non-sequential addresses: no merge, arrival order kept
        cap1.delete();
        snap = done_cnt1;
        start_dl();
        send_byte(25'd4, 8'h01, 1'b1, 1'b0);
        send_byte(25'd2, 8'h02, 1'b1, 1'b0);
        dl1 = 1'b0;
        wait_done(snap, "nonseq_done");
        check("nonseq_count", cap1.size(), 2);
        cap_word("nonseq_w0", 0, mk(22'd2, 16'h0100, 2'b01));
        cap_word("nonseq_w1", 1, mk(22'd1, 16'h0200, 2'b01));

        // Ack withheld: pacing, overflow and its clearing
        cap1.delete();
        ack_hold = 1'b1;
        start_dl();
        for (int k = 0; k < 16; k++) send_byte(25'(k), 8'(k + 'h40), 1'b0, 1'b0);
        repeat (2) @(negedge clk_sys);
        check("hold_clkref_high", clkref_n1, 1);
        check("hold_req_high", req1, 1);
        check("hold_overflow", ovf1, 1);
        snap = done_cnt1;
        repeat (20) @(negedge clk_sys);
        check("hold_req_stable", {req1, saddr1, smask1}, {1'b1, 22'd0, 2'b00});
        ack_hold = 1'b0;
        dl1 = 1'b0;
        wait_done(snap, "hold_done");
        check("overflow_sticky", ovf1, 1);
        snap = done_cnt1;
        dl1 = 1'b1;
        @(negedge clk_sys);
        check("overflow_cleared", ovf1, 0);
        dl1 = 1'b0;
        wait_done(snap, "hold2_done");

        // Swapped lanes with base offset on the second instance
        cap2.delete();
        dl2 = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("swab_clkref", clkref_n2, 0);
        wr2 = 1'b1; addr2 = 25'h11; dout2 = 8'h5A;
        @(negedge clk_sys);
        wr2 = 1'b0;
        dl2 = 1'b0;
        repeat (12) @(negedge clk_sys);
        check("swab_count", cap2.size(), 1);
        if (cap2.size() == 1) check_word("swab_word", cap2[0], mk(22'h108, 16'h5A00, 2'b01));
        check("swab_done", done_cnt2, 1);

        // Randomized downloads against a byte-stream reference model
        cap1.delete();
        exp_q.delete();
        ack_max = 4;
        spurious = 1'b1;
        for (int dn = 0; dn < 6; dn++) begin
            ba.delete(); bd.delete();
            n = $urandom_range(40, 1);
            prev = (dn == 2) ? 25'h7FFFE8 : 25'($urandom_range(200, 0));
            for (int j = 0; j < int'(n); j++) begin
                r = $urandom_range(99, 0);
                if (j == 0) a = prev;
                else if (r < 8) a = 25'($urandom_range(300, 0));
                else if (r < 13) a = 25'h800000 + 25'($urandom_range(1000, 0));
                else a = prev + 25'd1;
                prev = a;
                ba.push_back(a);
                bd.push_back(8'($urandom));
            end

            cv = 1'b0;
            for (int j = 0; j < int'(n); j++) begin
                a = ba[j];
                d = bd[j];
                if (a < 25'h800000) begin
                    wa = a[22:1];
                    bitm = a[0] ? 2'b01 : 2'b10;
                    if (cv && cw.addr == wa && (cw.mask & bitm) != 2'b00) begin
                        cw.mask = cw.mask & ~bitm;
                        if (a[0]) cw.data[7:0] = d; else cw.data[15:8] = d;
                    end else begin
                        if (cv) exp_q.push_back(cw);
                        cw = mk(wa, a[0] ? {8'h00, d} : {d, 8'h00}, ~bitm);
                        cv = 1'b1;
                    end
                end
            end
            if (cv) exp_q.push_back(cw);

            snap = done_cnt1;
            start_dl();
            for (int j = 0; j < int'(n); j++) send_byte(ba[j], bd[j], 1'b1, 1'b1);
            dl1 = 1'b0;
            // A stray strobe outside a download must be ignored
            wr1 = 1'b1; addr1 = 25'h55; dout1 = 8'hEE;
            @(negedge clk_sys);
            wr1 = 1'b0;
            wait_done(snap, $sformatf("rand%0d_done", dn));
            check($sformatf("rand%0d_done_once", dn), done_cnt1 - snap, 1);
        end
        spurious = 1'b0;
        check("rand_count", cap1.size(), exp_q.size());
        for (int j = 0; j < exp_q.size(); j++) cap_word($sformatf("rand_w%0d", j), j, exp_q[j]);
        check("rand_no_overflow", ovf1, 0);
        check("rand_idle", busy1, 0);

        // Reset while a request is outstanding with three words queued
        cap1.delete();
        ack_max = 0;
        ack_hold = 1'b1;
        start_dl();
        for (int k = 0; k < 6; k++) send_byte(25'(k), 8'(k + 1), 1'b0, 1'b0);
        repeat (2) @(negedge clk_sys);
        check("prerst_req", req1, 1);
        snap = done_cnt1;
        rst = 1'b1;
        dl1 = 1'b0;
        @(negedge clk_sys);
        check("midrst_req", req1, 0);
        check("midrst_mask", smask1, 2'b11);
        check("midrst_busy", busy1, 0);
        rst = 1'b0;
        ack_hold = 1'b0;
        repeat (15) @(negedge clk_sys);
        check("midrst_no_done", done_cnt1 - snap, 0);
        check("midrst_no_writes", cap1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
